debug_trace_buf: RTL

Retire-trace buffer that consumes the registered debug stream (retired PC plus valid-instruction flag) produced by the debug register stage of the single-cycle core. Every retired instruction is counted. When tracing is enabled, its PC and a sequence tag are queued in a show-ahead FIFO. Entries drain over a valid/ready interface towards the debug host (UART/JTAG bridge or logic analyser). Overflow is counted rather than back-pressuring the core, because the core cannot stall.

---
 rtl/debug_trace_buf.sv | 116 +++++++++++
 1 files changed

// File: rtl/debug_trace_buf.sv
// Retire-trace buffer: counts retired instructions and queues traced PC/tag pairs
// in a show-ahead FIFO; overflow is counted instead of stalling the core.
module debug_trace_buf #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              pc_i,
    input  logic                     valid_inst_i,
    input  logic                     trace_en_i,
    input  logic                     flush_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [31:0]              trace_pc_o,
    output logic [SEQ_W-1:0]         trace_seq_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic [31:0]              instret_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [31:0]        instret_q, instret_d;

    logic   empty, full, push_req, pop, push_ok, drop;
    entry_t head;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign push_req = valid_inst_i & trace_en_i & ~flush_i;
    assign pop      = ~empty & trace_ready_i & ~flush_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        instret_d  = instret_q + 32'(valid_inst_i);

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = '{pc: pc_i, seq: instret_q[SEQ_W-1:0]};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {DROP_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            instret_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            instret_q  <= instret_d;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign trace_valid_o = ~empty;
    assign trace_pc_o    = empty ? '0 : head.pc;
    assign trace_seq_o   = empty ? '0 : head.seq;
    assign level_o       = level_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign instret_o     = instret_q;

endmodule
